// File: rtl/game_pkg.sv
// Shared definitions for the game score block.
// Holds the BCD and segment widths, the blank segment code, and the
// digit-to-segment table (0-9). Every FND driver in the design uses this table.
// Segment codes here are active-high, ordered {g,f,e,d,c,b,a}.
// Polarity is applied at the output, after the blank mux.
package game_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b000_0000;

    localparam logic [SEG_W-1:0] SEG_TABLE [0:9] = '{
        7'h3F,  // 0
        7'h06,  // 1
        7'h5B,  // 2
        7'h4F,  // 3
        7'h66,  // 4
        7'h6D,  // 5
        7'h7D,  // 6
        7'h07,  // 7
        7'h7F,  // 8
        7'h6F   // 9
    };

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder for the score ripple chain.
//  a    in  4  current score digit
//  b    in  4  addend digit (0 above digit 1)
//  cin  in  1  carry from the digit below
//  sum  out 4  result digit, 0..9
//  cout out 1  carry to the digit above
module bcd_digit_add
    import game_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);

    logic [BCD_W:0] w_raw;

    // The largest raw value is 9+9+1 = 19, so one correction by -10 is
    // always enough.
    always_comb begin
        w_raw = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        if (w_raw > 5'd9) begin
            sum  = 4'(w_raw - 5'd10);
            cout = 1'b1;
        end else begin
            sum  = 4'(w_raw);
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/fnd_decoder.sv
// FND decoder: converts one BCD digit to active-high segments {g..a}.
// Codes 10..15 decode to blank.
//  i_Digit in  4  BCD digit
//  o_Seg   out 7  active-high segments
module fnd_decoder
    import game_pkg::*;
(
    input  logic [BCD_W-1:0] i_Digit,
    output logic [SEG_W-1:0] o_Seg
);

    always_comb begin
        o_Seg = SEG_BLANK;
        if (i_Digit <= 4'd9)
            o_Seg = SEG_TABLE[i_Digit];
    end

endmodule

// File: rtl/game_score_bcd.sv
// Game score keeper with a packed-BCD live score and a session high score.
// It drives one 7-segment FND per digit.
//  i_Clk     in   1           clock, rising edge
//  i_Rst     in   1           synchronous active-high reset
//  i_Clr     in   1           clear the live score (the high score is kept)
//  i_Add     in   1           add strobe, one event per cycle
//  i_AddVal  in   ADD_W       binary points; values above 99 clamp to 99
//  i_ShowHi  in   1           display the high score instead of the live score
//  o_Score   out  4*N_DIGITS  live score, packed BCD
//  o_HiScore out  4*N_DIGITS  high score, packed BCD
//  o_Sat     out  1           live score stuck at all nines
//  o_NewHigh out  1           high score beaten since the last clear
//  o_FND     out  7*N_DIGITS  segments {g..a} per digit, digit0 = LSBs
module game_score_bcd
    import game_pkg::*;
#(
    parameter int N_DIGITS  = 3,
    parameter int ADD_W     = 7,
    parameter int BLINK_DIV = 25,
    parameter bit LZ_BLANK  = 1'b1,
    parameter bit SEG_ON    = 1'b0
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic                      i_Clr,
    input  logic                      i_Add,
    input  logic [ADD_W-1:0]          i_AddVal,
    input  logic                      i_ShowHi,
    output logic [BCD_W*N_DIGITS-1:0] o_Score,
    output logic [BCD_W*N_DIGITS-1:0] o_HiScore,
    output logic                      o_Sat,
    output logic                      o_NewHigh,
    output logic [SEG_W*N_DIGITS-1:0] o_FND
);

    localparam int SW = BCD_W * N_DIGITS;
    localparam int CW = BLINK_DIV + 1;

    logic [SW-1:0]       r_score;
    logic [SW-1:0]       r_hi;
    logic                r_sat;
    logic                r_newhigh;
    logic [CW-1:0]       r_blink_cnt;

    logic [6:0]          w_add_clamp;
    logic [BCD_W-1:0]    w_add_tens;
    logic [BCD_W-1:0]    w_add_ones;
    logic [SW-1:0]       w_sum;
    logic [N_DIGITS:0]   w_carry;
    logic                w_hi_gt;
    logic                w_newhigh_next;
    logic [SW-1:0]       w_disp;
    logic                w_blink_off;
    logic [N_DIGITS-1:1] w_nz;
    logic [N_DIGITS-1:1] w_upper;

    // Clamp to 99, then split into tens and ones. The tens digit comes from
    // threshold compares, so no divider is needed.
    always_comb begin
        if (32'(i_AddVal) > 32'd99)
            w_add_clamp = 7'd99;
        else
            w_add_clamp = 7'(i_AddVal);
        w_add_tens = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            if (w_add_clamp >= 7'(10 * k))
                w_add_tens = 4'(k);
        end
        w_add_ones = 4'(w_add_clamp - 7'd10 * {3'b000, w_add_tens});
    end

    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_add
            logic [BCD_W-1:0] w_b;
            if (gi == 0) begin : g_b0
                assign w_b = w_add_ones;
            end else if (gi == 1) begin : g_b1
                assign w_b = w_add_tens;
            end else begin : g_bz
                assign w_b = 4'd0;
            end
            bcd_digit_add u_add (
                .a    (r_score[gi*BCD_W +: BCD_W]),
                .b    (w_b),
                .cin  (w_carry[gi]),
                .sum  (w_sum[gi*BCD_W +: BCD_W]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    // Packed BCD orders the same way as its value, so a plain unsigned
    // compare is enough.
    assign w_hi_gt        = (r_score > r_hi);
    assign w_newhigh_next = i_Clr ? 1'b0 : (r_newhigh | w_hi_gt);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_score     <= '0;
            r_hi        <= '0;
            r_sat       <= 1'b0;
            r_newhigh   <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            if (i_Clr) begin
                r_score <= '0;
                r_sat   <= 1'b0;
            end else if (i_Add && !r_sat) begin
                if (w_carry[N_DIGITS]) begin
                    r_score <= {N_DIGITS{4'h9}};
                    r_sat   <= 1'b1;
                end else begin
                    r_score <= w_sum;
                end
            end
            if (w_hi_gt)
                r_hi <= r_score;
            r_newhigh <= w_newhigh_next;
            // Restart the blink phase as a new record appears, so the first
            // half-period is always visible.
            if (w_newhigh_next && !r_newhigh)
                r_blink_cnt <= '0;
            else
                r_blink_cnt <= r_blink_cnt + CW'(1);
        end
    end

    assign o_Score   = r_score;
    assign o_HiScore = r_hi;
    assign o_Sat     = r_sat;
    assign o_NewHigh = r_newhigh;

    assign w_disp      = i_ShowHi ? r_hi : r_score;
    assign w_blink_off = r_newhigh & ~i_ShowHi & r_blink_cnt[BLINK_DIV];

    // w_upper[gi] is set when any digit at or above gi is nonzero. Digit 0
    // is never blanked, so the chain stops at 1.
    generate
        for (gi = 1; gi < N_DIGITS; gi++) begin : g_lz
            assign w_nz[gi] = |w_disp[gi*BCD_W +: BCD_W];
            if (gi == N_DIGITS - 1) begin : g_top
                assign w_upper[gi] = w_nz[gi];
            end else begin : g_mid
                assign w_upper[gi] = w_nz[gi] | w_upper[gi+1];
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_fnd
            logic [SEG_W-1:0] w_seg_raw;
            logic [SEG_W-1:0] w_seg_on;
            logic             w_blank;

            fnd_decoder u_dec (
                .i_Digit (w_disp[gi*BCD_W +: BCD_W]),
                .o_Seg   (w_seg_raw)
            );

            if (gi == 0) begin : g_d0
                assign w_blank = w_blink_off;
            end else begin : g_dn
                assign w_blank = w_blink_off | (LZ_BLANK & ~w_upper[gi]);
            end

            assign w_seg_on = w_blank ? SEG_BLANK : w_seg_raw;
            assign o_FND[gi*SEG_W +: SEG_W] = SEG_ON ? w_seg_on : ~w_seg_on;
        end
    endgenerate

endmodule
